// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_if
//   Instruction-memory request/acknowledge bus between the fetch unit and the
//   instruction memory.
//   imem_req   : fetch request, held until acknowledged
//   imem_addr  : fetch address, stable while imem_req is high
//   imem_ack   : memory acknowledge; imem_rdata is valid in the same cycle
//   imem_rdata : fetched instruction word
//   master modport = fetch unit, slave modport = memory.
// ---------------------------------------------------------------------------
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Front end of the MIPS core. Holds the PC, fetches one word per instruction
//   over the imem req/ack bus, latches it into the instruction register and
//   presents the decode fields. When the datapath retires the instruction, the
//   next PC is selected from the controller's pcsrc/jmp1/jmp2.
//
// Ports
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   imem            : instruction-memory bus (master side)
//   retire          : datapath done with the current instruction (pulse)
//   pcsrc           : branch taken
//   jmp1, jmp2      : next-PC select (1x sequential/branch, 00 J-target, 01 jr)
//   jr_target       : register value for jump-register
//   instr, opcode, func, rs, rt, rd, imm16 : instruction register and fields
//   pc, pc_plus4    : current instruction address and its link value
//   instr_valid     : instr holds a word awaiting retire
//   fetch_err       : sticky fetch-timeout fault, cleared only by rst
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    instr_fetch_unit_if.master         imem,
    input  logic                       retire,
    input  logic                       pcsrc,
    input  logic                       jmp1,
    input  logic                       jmp2,
    input  logic [31:0]                jr_target,
    output logic [31:0]                instr,
    output logic [5:0]                 opcode,
    output logic [5:0]                 func,
    output logic [4:0]                 rs,
    output logic [4:0]                 rt,
    output logic [4:0]                 rd,
    output logic [15:0]                imm16,
    output logic [31:0]                pc,
    output logic [31:0]                pc_plus4,
    output logic                       instr_valid,
    output logic                       fetch_err
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } state_e;

    // The fault is taken on the WAIT cycle where the counter would reach MAX_WAIT.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;

    logic [31:0] pc_plus4_s;
    logic [31:0] branch_off_s;
    logic [31:0] next_pc_s;
    logic        fetching_s;

    assign pc_plus4_s = pc_q + 32'd4;

    // Next-PC selection, used only when an instruction retires.
    always_comb begin
        branch_off_s = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        if (jmp1) begin
            if (pcsrc) begin
                next_pc_s = pc_plus4_s + branch_off_s;
            end else begin
                next_pc_s = pc_plus4_s;
            end
        end else if (jmp2) begin
            next_pc_s = jr_target;
        end else begin
            next_pc_s = {pc_plus4_s[31:28], instr_q[25:0], 2'b00};
        end
    end

    // Fetch FSM next-state and datapath-register update logic.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            S_FETCH: begin
                if (imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    state_d = S_HOLD;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A late ack in the timeout cycle still completes the fetch.
                if (imem.imem_ack) begin
                    instr_d    = imem.imem_rdata;
                    wait_cnt_d = 8'd0;
                    state_d    = S_HOLD;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    wait_cnt_d = 8'd0;
                    state_d    = S_FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_HOLD: begin
                if (retire) begin
                    pc_d    = next_pc_s;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // The request is a decode of the state register; it is masked by rst so
    // that it is low during reset even though reset parks the FSM in FETCH,
    // and rises in the very first cycle after rst falls.
    assign fetching_s     = (state_q == S_FETCH) || (state_q == S_WAIT);
    assign imem.imem_req  = fetching_s & ~rst;
    assign imem.imem_addr = pc_q;

    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign rs          = instr_q[25:21];
    assign rt          = instr_q[20:16];
    assign rd          = instr_q[15:11];
    assign func        = instr_q[5:0];
    assign imm16       = instr_q[15:0];
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_s;
    assign instr_valid = (state_q == S_HOLD);
    assign fetch_err   = (state_q == S_FAULT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        retire = 1'b0, pcsrc = 1'b0, jmp1 = 1'b1, jmp2 = 1'b0;
    logic [31:0] jr_target = 32'd0;
    logic [31:0] instr, pc, pc_plus4;
    logic [5:0]  opcode, func;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;
    logic        instr_valid, fetch_err;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(.RESET_PC(RESET_PC), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .imem(bus.master),
        .retire(retire), .pcsrc(pcsrc), .jmp1(jmp1), .jmp2(jmp2), .jr_target(jr_target),
        .instr(instr), .opcode(opcode), .func(func), .rs(rs), .rt(rt), .rd(rd),
        .imm16(imm16), .pc(pc), .pc_plus4(pc_plus4),
        .instr_valid(instr_valid), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // fetching: a request is outstanding; misses: ack-less request cycles so far.
    logic        m_fetching = 1'b1;
    logic        m_valid    = 1'b0;
    logic        m_err      = 1'b0;
    int          m_misses   = 0;
    logic [31:0] m_pc       = RESET_PC;
    logic [31:0] m_instr    = 32'd0;

    function automatic logic [31:0] ref_next_pc(input logic [31:0] cur_pc, input logic [31:0] word,
                                                input logic ps, input logic j1, input logic j2,
                                                input logic [31:0] jr);
        logic [31:0] seq;
        int          off;
        seq = cur_pc + 32'd4;
        off = $signed(word[15:0]);
        if (j1) return ps ? seq + 32'(off * 4) : seq;
        if (j2) return jr;
        return (seq & 32'hF000_0000) | ({6'd0, word[25:0]} << 2);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_fetching <= 1'b1; m_valid <= 1'b0; m_err <= 1'b0;
            m_misses <= 0; m_pc <= RESET_PC; m_instr <= 32'd0;
        end else if (m_fetching) begin
            if (bus.imem_ack) begin
                m_instr <= bus.imem_rdata; m_fetching <= 1'b0; m_valid <= 1'b1; m_misses <= 0;
            end else if (m_misses == MAX_WAIT) begin
                // This is the (MAX_WAIT+1)-th request cycle without an ack.
                m_fetching <= 1'b0; m_err <= 1'b1;
            end else begin
                m_misses <= m_misses + 1;
            end
        end else if (m_valid && retire) begin
            m_pc <= ref_next_pc(m_pc, m_instr, pcsrc, jmp1, jmp2, jr_target);
            m_valid <= 1'b0; m_fetching <= 1'b1;
        end
    end

    // Compare process: every falling edge, DUT outputs against the model.
    always @(negedge clk) begin
        chk("req", {31'd0, bus.imem_req}, {31'd0, m_fetching & ~rst});
        if (m_fetching && !rst) chk("addr", bus.imem_addr, m_pc);
        chk("valid", {31'd0, instr_valid}, {31'd0, m_valid});
        chk("err", {31'd0, fetch_err}, {31'd0, m_err});
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("instr", instr, m_instr);
        chk("opcode", {26'd0, opcode}, m_instr >> 26);
        chk("rs", {27'd0, rs}, (m_instr >> 21) & 32'h1F);
        chk("rt", {27'd0, rt}, (m_instr >> 16) & 32'h1F);
        chk("rd", {27'd0, rd}, (m_instr >> 11) & 32'h1F);
        chk("imm16", {16'd0, imm16}, m_instr & 32'hFFFF);
        chk("func", {26'd0, func}, m_instr & 32'h3F);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_word(input logic [31:0] w);
        bus.imem_ack = 1'b1; bus.imem_rdata = w;
        step();
        bus.imem_ack = 1'b0;
    endtask

    task automatic do_retire(input logic j1, input logic j2, input logic ps, input logic [31:0] jr);
        jmp1 = j1; jmp2 = j2; pcsrc = ps; jr_target = jr; retire = 1'b1;
        step();
        retire = 1'b0;
    endtask

    initial begin
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'd0;
        repeat (2) step();
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_pc", pc, RESET_PC);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);

        // 1: zero-wait ack of addi, sequential retire
        rst = 1'b0; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h2009_0005;
        #1;
        chk("t1_req", {31'd0, bus.imem_req}, 32'd1);
        chk("t1_addr", bus.imem_addr, 32'h0);
        step();
        bus.imem_ack = 1'b0;
        chk("t1_valid", {31'd0, instr_valid}, 32'd1);
        chk("t1_opcode", {26'd0, opcode}, 32'h08);
        chk("t1_imm16", {16'd0, imm16}, 32'h5);
        chk("t1_rt", {27'd0, rt}, 32'd9);
        do_retire(1'b1, 1'b0, 1'b0, 32'd0);
        chk("t1_addr2", bus.imem_addr, 32'h4);
        chk("t1_req2", {31'd0, bus.imem_req}, 32'd1);

        // 2: beq with offset -1 at pc 0x10 loops to itself
        fetch_word(32'h0000_0008);
        do_retire(1'b0, 1'b1, 1'b0, 32'h10);
        fetch_word(32'h1000_FFFF);
        do_retire(1'b1, 1'b0, 1'b1, 32'd0);
        chk("t2_addr", bus.imem_addr, 32'h10);

        // 3: J-target keeps the upper nibble of pc+4
        fetch_word(32'h0000_0008);
        do_retire(1'b0, 1'b1, 1'b0, 32'h4000_0000);
        fetch_word(32'h0800_0040);
        do_retire(1'b0, 1'b0, 1'b0, 32'd0);
        chk("t3_addr", bus.imem_addr, 32'h4000_0100);

        // 4: jr, then jal at 0x20
        fetch_word(32'h0000_0008);
        do_retire(1'b0, 1'b1, 1'b0, 32'h80);
        chk("t4_addr", bus.imem_addr, 32'h80);
        fetch_word(32'h0000_0008);
        do_retire(1'b0, 1'b1, 1'b0, 32'h20);
        fetch_word(32'h0C00_0000);
        chk("t4_pc", pc, 32'h20);
        chk("t4_link", pc_plus4, 32'h24);
        do_retire(1'b0, 1'b0, 1'b0, 32'd0);
        chk("t4_addr2", bus.imem_addr, 32'h0);

        // 5: ack delayed 3 cycles
        for (int i = 0; i < 3; i++) begin
            chk("t5_req_hold", {31'd0, bus.imem_req}, 32'd1);
            chk("t5_addr_hold", bus.imem_addr, 32'h0);
            step();
        end
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_0020;
        #1;
        chk("t5_valid_pre", {31'd0, instr_valid}, 32'd0);
        step();
        bus.imem_ack = 1'b0;
        chk("t5_valid", {31'd0, instr_valid}, 32'd1);
        // ack in the last possible cycle still wins over the timeout
        do_retire(1'b1, 1'b0, 1'b0, 32'd0);
        repeat (MAX_WAIT) step();
        chk("t5_last_req", {31'd0, bus.imem_req}, 32'd1);
        fetch_word(32'h0000_0020);
        chk("t5_late_valid", {31'd0, instr_valid}, 32'd1);
        chk("t5_late_err", {31'd0, fetch_err}, 32'd0);
        // no ack at all -> fault
        do_retire(1'b1, 1'b0, 1'b0, 32'd0);
        repeat (MAX_WAIT + 1) step();
        chk("t5_err", {31'd0, fetch_err}, 32'd1);
        chk("t5_err_req", {31'd0, bus.imem_req}, 32'd0);
        rst = 1'b1;
        #1;
        chk("t5_err_clr", {31'd0, fetch_err}, 32'd0);
        step();
        rst = 1'b0;

        // 6: reset in WAIT and in HOLD
        step();
        chk("t6_wait_req", {31'd0, bus.imem_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_wait_rst_req", {31'd0, bus.imem_req}, 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("t6_restart_addr", bus.imem_addr, RESET_PC);
        fetch_word(32'h2009_0005);
        chk("t6_hold_valid", {31'd0, instr_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_hold_rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("t6_hold_rst_req", {31'd0, bus.imem_req}, 32'd0);
        step();
        rst = 1'b0;

        // Randomised traffic: acks, retires and selects arrive at any time.
        for (int n = 0; n < 4000; n++) begin
            rst = m_err || ($urandom_range(0, 299) == 0);
            bus.imem_ack   = ($urandom_range(0, 3) == 0);
            bus.imem_rdata = $urandom;
            retire    = ($urandom_range(0, 2) == 0);
            pcsrc     = $urandom_range(0, 1);
            jmp1      = $urandom_range(0, 1);
            jmp2      = $urandom_range(0, 1);
            jr_target = $urandom;
            step();
        end
        rst = 1'b0; bus.imem_ack = 1'b0; retire = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
